// File: rtl/param_updown_counter.sv
// -----------------------------------------------------------------------------
// param_updown_counter
//
// Generic synchronous up/down event/cycle counter. Every flop is clocked by
// clk. The counter runs over 0..MAX_COUNT (modulus MAX_COUNT+1) and supports:
//   - a direction control
//   - an enable that gates a clock-enable prescaler
//   - a saturating parallel load
//   - a synchronous clear
//   - a one-cycle wrap pulse and a sticky wrap flag
//
// Parameters
//   WIDTH     count register width in bits (>=1)
//   MAX_COUNT terminal value, must be <= 2**WIDTH-1
//   PRESCALE  enabled cycles per count step (>=1), 1 = step every enabled cycle
//
// Ports
//   clk       in   rising-edge clock
//   reset     in   synchronous reset, active low, overrides everything
//   en        in   count enable (freezes prescaler and count when low)
//   dir       in   1 = count up, 0 = count down (sampled on each tick)
//   clr       in   synchronous clear of count, prescaler, wrap and wrapped
//   load      in   parallel load strobe (ignores en, beats a coincident tick)
//   load_val  in   value to load, saturated to MAX_COUNT
//   count_out out  current count (registered)
//   wrap      out  one-cycle pulse while count_out shows a wrapped value
//   wrapped   out  sticky: a wrap happened since the last reset/clr
//
// Edge priority: reset > clr > load > count step > hold.
// All outputs are registered; there is no combinational input-to-output path.
// -----------------------------------------------------------------------------
module param_updown_counter #(
   parameter int WIDTH     = 4,
   parameter int MAX_COUNT = (1 << WIDTH) - 1,
   parameter int PRESCALE  = 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             en,
   input  logic             dir,
   input  logic             clr,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   output logic [WIDTH-1:0] count_out,
   output logic             wrap,
   output logic             wrapped
);

   // Terminal value at register width. For WIDTH=32 the default expression
   // overflows to -1, which truncates to all ones, so it is still correct.
   localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MAX_COUNT);

   // Prescaler width. A nominal 1-bit width is kept for PRESCALE=1 so the
   // declaration stays legal, but no register is built in that case.
   localparam int PS_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

   logic             tick;       // a count step is due at this edge
   logic             at_max;
   logic             at_zero;
   logic             step_wrap;  // the step due at this edge crosses the modulus
   logic [WIDTH-1:0] step_val;   // count value after one step in direction dir
   logic [WIDTH-1:0] load_sat;   // load_val clipped to MAX_COUNT

   // --------------------------------------------------------------------------
   // Prescaler
   // Advances only on enabled cycles with no clr/load. It returns to 0 on the
   // tick, and clr/load also clear it. A load that coincides with a tick
   // therefore discards that tick and restarts a full prescale period.
   // --------------------------------------------------------------------------
   generate
      if (PRESCALE <= 1) begin : g_no_ps
         assign tick = en;
      end else begin : g_ps
         localparam logic [PS_W-1:0] PS_LAST = PS_W'(PRESCALE - 1);

         logic [PS_W-1:0] ps_cnt;

         assign tick = en && (ps_cnt == PS_LAST);

         always_ff @(posedge clk) begin
            if (!reset || clr || load) begin
               ps_cnt <= '0;
            end else if (tick) begin
               ps_cnt <= '0;
            end else if (en) begin
               ps_cnt <= ps_cnt + PS_W'(1);
            end
         end
      end
   endgenerate

   // --------------------------------------------------------------------------
   // Next-step arithmetic, modulo MAX_COUNT+1
   // --------------------------------------------------------------------------
   always_comb begin
      at_max    = (count_out == MAX_V);
      at_zero   = (count_out == '0);
      step_wrap = dir ? at_max : at_zero;
      step_val  = count_out;
      if (dir) begin
         step_val = at_max ? '0 : count_out + WIDTH'(1);
      end else begin
         step_val = at_zero ? MAX_V : count_out - WIDTH'(1);
      end
      // Saturate so the counter can never leave its 0..MAX_COUNT range.
      load_sat = (load_val > MAX_V) ? MAX_V : load_val;
   end

   // --------------------------------------------------------------------------
   // Count, wrap pulse and sticky wrap flag
   // wrap is registered together with the count, so it is high exactly in the
   // cycle where count_out shows the wrapped value. Any cycle without a
   // wrapping step drops it again.
   // --------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (!reset) begin
         count_out <= '0;
         wrap      <= 1'b0;
         wrapped   <= 1'b0;
      end else if (clr) begin
         count_out <= '0;
         wrap      <= 1'b0;
         wrapped   <= 1'b0;
      end else if (load) begin
         // A load leaves the sticky flag alone; only reset/clr rearm it.
         count_out <= load_sat;
         wrap      <= 1'b0;
      end else if (tick) begin
         count_out <= step_val;
         wrap      <= step_wrap;
         if (step_wrap) begin
            wrapped <= 1'b1;
         end
      end else begin
         wrap      <= 1'b0;
      end
   end

endmodule
